dtlb_assoc: RTL and testbench
=============================

// Module: dtlb_assoc
// PURPOSE
//  Parametrised fully-associative data TLB for the TL stage. Translates the EX-stage virtual
//  address combinationally, in the same cycle. Adds in-place VPN update, invalid-first/round-robin
//  replacement, global flush, per-thread miss-pending tracking and saturating hit/miss counters.
//  It sits between the EX/TL pipeline register and the D-cache paddr input.
// PARAMETERS
//  N_ENTRIES  8   TLB entries; power of two, >=2
//  VADDR_W    20  virtual address width
//  PADDR_W    20  physical address width
//  OFFSET_W   12  page offset width; VPN = VADDR_W-OFFSET_W, PPN = PADDR_W-OFFSET_W
//  N_THREADS  4   hardware threads; TID_W = $clog2(N_THREADS)
//  CNT_W      16  statistics counter width
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous, active-low reset
//  mode          in   1          1 = supervisor (bypass translation)
//  req_valid     in   1          instruction in TL is valid
//  req_mem       in   1          instruction is a load/store
//  req_thread    in   TID_W      thread of the request
//  req_vaddr     in   VADDR_W    virtual address
//  paddr         out  PADDR_W    translated address (combinational)
//  miss          out  1          translation miss (combinational)
//  write_en      in   1          TLBWRITE commit from WB
//  write_thread  in   TID_W      thread issuing the TLBWRITE
//  write_vpn     in   VPN        VPN to install
//  write_ppn     in   PPN        PPN to install
//  flush         in   1          invalidate all entries
//  miss_pending  out  N_THREADS  per-thread outstanding D-TLB miss (registered)
//  hit_count     out  CNT_W      lookups that hit (registered)
//  miss_count    out  CNT_W      lookups that missed (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): all valid bits=0, rr_ptr=0, miss_pending=0, hit_count=miss_count=0.
//    Entry VPN/PPN storage is don't-care.
//  - lookup = req_valid & req_mem & ~mode. hit = lookup & some valid entry's VPN == req_vaddr[VADDR_W-1:OFFSET_W].
//    At most one entry matches, guaranteed by the write rule.
//  - paddr: mode=1 -> req_vaddr zero-extended/truncated to PADDR_W. Hit -> {PPN, req_vaddr[OFFSET_W-1:0]}.
//    Otherwise paddr = 0. miss = lookup & ~hit. Zero latency.
//  - A lookup sees table contents as of the start of the cycle. No write-to-lookup bypass:
//    a write and a lookup of the same VPN in one cycle still reports a miss.
//  - Write (write_en=1, flush=0), applied at the clock edge:
//    - Matching valid VPN -> overwrite that entry's PPN; rr_ptr unchanged.
//    - Else if any entry is invalid -> fill the lowest-index invalid entry; rr_ptr unchanged.
//    - Else -> replace entry rr_ptr; rr_ptr = (rr_ptr+1) mod N_ENTRIES.
//  - flush=1 -> all valid=0, rr_ptr=0, miss_pending=0. Flush overrides a same-cycle write
//    (write dropped) and a same-cycle miss set.
//  - miss_pending[t]: set at the edge when miss=1 and req_thread==t.
//    Cleared when write_en=1 and write_thread==t. Clear wins over a same-cycle set for the same thread.
//    Holds otherwise. Repeated misses while set have no further effect.
//  - Counters: each lookup cycle increments hit_count (hit) or miss_count (miss).
//    Both saturate at 2^CNT_W-1; neither wraps. Flush does not clear counters.
//  - mode=1 or req_mem=0 or req_valid=0: miss=0, no counter or pending update.
// TESTING
//  1. Reset then lookup vaddr 0x12345, mode=0 -> miss=1, paddr=0; next cycle miss_pending[thr]=1, miss_count=1.
//  2. Write vpn 0x12 -> ppn 0xAB, then lookup 0x12345 -> miss=0, paddr=0xAB345, hit_count=1.
//     Writing thread's miss_pending clears.
//  3. Fill 8 distinct VPNs, then write a 9th -> replaces entry 0; rr_ptr=1. A 10th write replaces entry 1.
//     Lookup of the first VPN misses.
//  4. Rewrite an existing VPN with a new PPN -> same entry updated, rr_ptr unchanged, no duplicate hit.
//  5. Same cycle: flush=1, write_en=1, miss -> all entries invalid, miss_pending=0, write dropped.
//  6. mode=1, vaddr 0xFFFFF -> paddr=0xFFFFF, miss=0, counters unchanged.
//     Then drive 2^CNT_W+3 misses -> miss_count stays at all-ones.
//  7. Assert rst low mid-sequence with valid entries -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dtlb_assoc.sv
// Fully-associative D-TLB: same-cycle VA->PA lookup, in-place/invalid-first/round-robin fill.
// Latency: paddr/miss combinational (0 cycles); table, pending bits and counters update at clk edge.
// Backpressure: none; one lookup and one write accepted every cycle, miss_pending tells the pipe to stall.
module dtlb_assoc #(
    parameter int N_ENTRIES = 8,
    parameter int VADDR_W   = 20,
    parameter int PADDR_W   = 20,
    parameter int OFFSET_W  = 12,
    parameter int N_THREADS = 4,
    parameter int CNT_W     = 16,
    localparam int TID_W    = $clog2(N_THREADS),
    localparam int VPN_W    = VADDR_W - OFFSET_W,
    localparam int PPN_W    = PADDR_W - OFFSET_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 req_valid,
    input  logic                 req_mem,
    input  logic [TID_W-1:0]     req_thread,
    input  logic [VADDR_W-1:0]   req_vaddr,
    output logic [PADDR_W-1:0]   paddr,
    output logic                 miss,
    input  logic                 write_en,
    input  logic [TID_W-1:0]     write_thread,
    input  logic [VPN_W-1:0]     write_vpn,
    input  logic [PPN_W-1:0]     write_ppn,
    input  logic                 flush,
    output logic [N_THREADS-1:0] miss_pending,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int BYP_W = (VADDR_W > PADDR_W) ? VADDR_W : PADDR_W;

    // Translation table; only the valid bits need a reset value.
    logic [N_ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]     vpn_q [N_ENTRIES];
    logic [PPN_W-1:0]     ppn_q [N_ENTRIES];
    logic [IDX_W-1:0]     rr_ptr;

    logic                 lookup;
    logic                 tbl_match;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [VPN_W-1:0]     req_vpn;
    logic [BYP_W-1:0]     byp_ext;

    logic                 wr_fire;
    logic                 wr_hit;
    logic [IDX_W-1:0]     wr_hit_idx;
    logic                 any_free;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_evict;

    assign req_vpn = req_vaddr[VADDR_W-1:OFFSET_W];
    assign lookup  = req_valid & req_mem & ~mode;
    assign hit     = lookup & tbl_match;
    assign miss    = lookup & ~tbl_match;
    assign byp_ext = BYP_W'(req_vaddr);
    assign wr_fire = write_en & ~flush;

    // CAM search of the request VPN against the table as it stood at the start of the cycle.
    always_comb begin
        tbl_match = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == req_vpn)) begin
                tbl_match = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    // Physical address: supervisor bypass, translated on hit, zero otherwise.
    always_comb begin
        paddr = '0;
        if (mode) begin
            paddr = byp_ext[PADDR_W-1:0];
        end else if (hit) begin
            paddr = {ppn_q[hit_idx], req_vaddr[OFFSET_W-1:0]};
        end
    end

    // Pick the write slot: existing VPN first, then lowest invalid entry, then round-robin victim.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        any_free   = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == write_vpn)) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IDX_W'(i);
            end
        end
        // Scan downwards so the lowest free index is the one left standing.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        wr_evict = ~wr_hit & ~any_free;
        if (wr_hit) begin
            wr_idx = wr_hit_idx;
        end else if (any_free) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = rr_ptr;
        end
    end

    // Valid bits and replacement pointer; flush beats a same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rr_ptr  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            rr_ptr  <= '0;
        end else if (write_en) begin
            valid_q[wr_idx] <= 1'b1;
            if (wr_evict) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    // Entry payload storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            vpn_q[wr_idx] <= write_vpn;
            ppn_q[wr_idx] <= write_ppn;
        end
    end

    // Per-thread pending miss: a TLBWRITE from the thread clears it, and wins over a new miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_pending <= '0;
        end else if (flush) begin
            miss_pending <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                if (write_en && (write_thread == TID_W'(t))) begin
                    miss_pending[t] <= 1'b0;
                end else if (miss && (req_thread == TID_W'(t))) begin
                    miss_pending[t] <= 1'b1;
                end
            end
        end
    end

    // Saturating hit/miss statistics; flush leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dtlb_assoc.sv
// Bench for dtlb_assoc: directed scenarios with literal expectations, then random traffic.
// Latency: outputs compared every falling edge against an in-bench table model.
// Backpressure: not applicable; stimulus applied every cycle.
module tb_dtlb_assoc;

    localparam int NE  = 8;
    localparam int VW  = 20;
    localparam int PW  = 20;
    localparam int OW  = 12;
    localparam int NT  = 4;
    localparam int CW  = 6;
    localparam int TW  = 2;
    localparam int VPW = VW - OW;
    localparam int PPW = PW - OW;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode, req_valid, req_mem, write_en, flush;
    logic [TW-1:0]  req_thread, write_thread;
    logic [VW-1:0]  req_vaddr;
    logic [VPW-1:0] write_vpn;
    logic [PPW-1:0] write_ppn;
    logic [PW-1:0]  paddr;
    logic           miss;
    logic [NT-1:0]  miss_pending;
    logic [CW-1:0]  hit_count, miss_count;

    dtlb_assoc #(
        .N_ENTRIES(NE), .VADDR_W(VW), .PADDR_W(PW), .OFFSET_W(OW),
        .N_THREADS(NT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req_mem(req_mem),
        .req_thread(req_thread), .req_vaddr(req_vaddr), .paddr(paddr), .miss(miss),
        .write_en(write_en), .write_thread(write_thread), .write_vpn(write_vpn),
        .write_ppn(write_ppn), .flush(flush), .miss_pending(miss_pending),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit             m_val [NE];
    logic [VPW-1:0] m_vpn [NE];
    logic [PPW-1:0] m_ppn [NE];
    int             m_rr;
    bit   [NT-1:0]  m_pend;
    int             m_hit, m_miss;
    int             m_idx, m_slot;
    bit             m_lk;

    function automatic int m_find(input logic [VPW-1:0] v);
        for (int i = 0; i < NE; i++)
            if (m_val[i] && m_vpn[i] == v) return i;
        return -1;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < NE; i++)
            if (!m_val[i]) return i;
        return -1;
    endfunction

    function automatic bit m_lookup();
        return req_valid && req_mem && !mode;
    endfunction

    function automatic logic [PW-1:0] exp_paddr();
        int i;
        if (mode) return PW'(req_vaddr);
        i = m_find(req_vaddr[VW-1:OW]);
        if (m_lookup() && i >= 0) return {m_ppn[i], req_vaddr[OW-1:0]};
        return '0;
    endfunction

    function automatic bit exp_miss();
        return m_lookup() && (m_find(req_vaddr[VW-1:OW]) < 0);
    endfunction

    // Model state advances on the same edge as the DUT, reset asynchronously.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NE; i++) m_val[i] = 1'b0;
            m_rr = 0; m_pend = '0; m_hit = 0; m_miss = 0;
        end else begin
            m_lk  = m_lookup();
            m_idx = m_find(req_vaddr[VW-1:OW]);
            if (m_lk && m_idx >= 0 && m_hit  < CMAX) m_hit++;
            if (m_lk && m_idx <  0 && m_miss < CMAX) m_miss++;
            if (flush) begin
                for (int i = 0; i < NE; i++) m_val[i] = 1'b0;
                m_rr = 0; m_pend = '0;
            end else begin
                for (int t = 0; t < NT; t++) begin
                    if (write_en && write_thread == TW'(t)) m_pend[t] = 1'b0;
                    else if (m_lk && m_idx < 0 && req_thread == TW'(t)) m_pend[t] = 1'b1;
                end
                if (write_en) begin
                    m_slot = m_find(write_vpn);
                    if (m_slot < 0) m_slot = m_first_free();
                    if (m_slot < 0) begin
                        m_slot = m_rr;
                        m_rr = (m_rr + 1) % NE;
                    end
                    m_val[m_slot] = 1'b1;
                    m_vpn[m_slot] = write_vpn;
                    m_ppn[m_slot] = write_ppn;
                end
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_paddr", paddr, exp_paddr());
            chk("cyc_miss", miss, exp_miss());
            chk("cyc_pending", miss_pending, m_pend);
            chk("cyc_hit_count", hit_count, m_hit);
            chk("cyc_miss_count", miss_count, m_miss);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        req_valid = 0; req_mem = 0; mode = 0; write_en = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [VW-1:0] v, input logic [TW-1:0] thr);
        req_valid = 1; req_mem = 1; mode = 0; req_vaddr = v; req_thread = thr;
    endtask

    task automatic wr(input logic [VPW-1:0] v, input logic [PPW-1:0] p, input logic [TW-1:0] thr);
        write_en = 1; write_vpn = v; write_ppn = p; write_thread = thr;
    endtask

    task automatic look_chk(input string name, input logic [VW-1:0] v,
                            input logic exp_m, input logic [PW-1:0] exp_pa);
        lookup(v, 0);
        #1;
        chk({name, "_miss"}, miss, exp_m);
        chk({name, "_paddr"}, paddr, exp_pa);
        tick();
        idle();
    endtask

    initial begin
        idle();
        req_vaddr = '0; req_thread = '0; write_thread = '0; write_vpn = '0; write_ppn = '0;
        #2 rst = 0;
        #1;
        chk("rst_pending", miss_pending, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_miss", miss, 0);
        @(posedge clk); #1 rst = 1;
        chk_en = 1;

        // Cold miss.
        lookup(20'h12345, 1);
        #1;
        chk("t1_miss", miss, 1);
        chk("t1_paddr", paddr, 0);
        tick(); idle();
        chk("t1_pending", miss_pending, 4'b0010);
        chk("t1_miss_count", miss_count, 1);

        // Install and hit; writer's pending bit clears.
        wr(8'h12, 8'hAB, 1);
        tick(); idle();
        chk("t2_pending", miss_pending, 0);
        lookup(20'h12345, 0);
        #1;
        chk("t2_paddr", paddr, 20'hAB345);
        chk("t2_miss", miss, 0);
        tick(); idle();
        chk("t2_hit_count", hit_count, 1);

        // Fill the table, then two round-robin evictions (entries 0 and 1).
        flush = 1; tick(); idle();
        for (int i = 0; i < 10; i++) begin
            wr(VPW'(8'h20 + i), PPW'(8'h80 + i), 0);
            tick(); idle();
        end
        look_chk("t3_evict0", 20'h20000, 1, 20'h0);
        look_chk("t3_evict1", 20'h21000, 1, 20'h0);
        look_chk("t3_new9",   20'h28ABC, 0, 20'h88ABC);
        look_chk("t3_keep2",  20'h22010, 0, 20'h82010);

        // In-place update keeps the pointer at entry 2.
        wr(8'h23, 8'h55, 0); tick(); idle();
        look_chk("t4_update", 20'h23001, 0, 20'h55001);
        wr(8'h2A, 8'h9A, 0); tick(); idle();
        look_chk("t4_evict2", 20'h22000, 1, 20'h0);
        look_chk("t4_kept",   20'h23001, 0, 20'h55001);
        look_chk("t4_new",    20'h2A777, 0, 20'h9A777);

        // Flush + write + miss in one cycle.
        lookup(20'h40000, 2);
        wr(8'h30, 8'h11, 3);
        flush = 1;
        #1;
        chk("t5_miss", miss, 1);
        tick(); idle();
        chk("t5_pending", miss_pending, 0);
        look_chk("t5_dropped", 20'h30000, 1, 20'h0);
        look_chk("t5_flushed", 20'h23001, 1, 20'h0);

        // Supervisor bypass, then drive the miss counter into saturation.
        req_valid = 1; req_mem = 1; mode = 1; req_vaddr = 20'hFFFFF;
        #1;
        chk("t6_bypass_paddr", paddr, 20'hFFFFF);
        chk("t6_bypass_miss", miss, 0);
        tick(); idle();
        for (int i = 0; i < CMAX + 4; i++) begin
            lookup(20'h77000, 2);
            tick();
        end
        idle();
        chk("t6_sat", miss_count, CMAX);

        // Random traffic over a small VPN pool larger than the table.
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 9) != 0);
            req_mem    = ($urandom_range(0, 5) != 0);
            mode       = ($urandom_range(0, 15) == 0);
            req_vaddr  = {VPW'(8'h60 + $urandom_range(0, 11)), OW'($urandom)};
            req_thread = TW'($urandom);
            write_en   = ($urandom_range(0, 9) < 3);
            write_vpn  = VPW'(8'h60 + $urandom_range(0, 11));
            write_ppn  = PPW'($urandom);
            write_thread = TW'($urandom);
            flush      = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();

        // Asynchronous reset mid-sequence with live entries.
        flush = 1; tick(); idle();
        wr(8'h50, 8'h05, 0); tick();
        wr(8'h51, 8'h06, 0); tick(); idle();
        lookup(20'h99000, 3); tick(); idle();
        chk("t7_pending_pre", miss_pending, 4'b1000);
        lookup(20'h50123, 0);
        #1;
        chk("t7_hit_pre", paddr, 20'h05123);
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("t7_miss_async", miss, 1);
        chk("t7_paddr_async", paddr, 0);
        chk("t7_pending_async", miss_pending, 0);
        chk("t7_hit_count_async", hit_count, 0);
        chk("t7_miss_count_async", miss_count, 0);
        @(posedge clk); #1 rst = 1;
        idle();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
